// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes, ALU encoding, FSM states and funct3 decode helper
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_e;
  // Base ALU op selected by funct3 alone (funct7 variants handled by the decoder)
  function automatic alu_op_e f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: instruction handshake plus datapath control bundle
interface cpu_ctrl_if;
  import cpu_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in;
  logic              zero;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [3:0]        alu_op;
  logic              alu_src_imm;
  logic [XLEN-1:0]   imm;
  logic              rf_we;
  logic              retire;
  logic              illegal;
  logic              zero_q;
  modport slave (
    input  in_valid, in, zero,
    output in_ready, rs1_addr, rs2_addr, rd_addr, alu_op, alu_src_imm, imm,
           rf_we, retire, illegal, zero_q
  );
  modport master (
    output in_valid, in, zero,
    input  in_ready, rs1_addr, rs2_addr, rd_addr, alu_op, alu_src_imm, imm,
           rf_we, retire, illegal, zero_q
  );
endinterface

// File: rtl/cpu_decode.sv
// cpu_decode: combinational RV32I R/I-type ALU instruction decoder
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [3:0]        alu_op,
  output logic              alu_src_imm,
  output logic [XLEN-1:0]   imm,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  output logic [REG_AW-1:0] rd_addr,
  output logic              illegal
);
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rd_addr = instr[11:7];
  assign imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
  // Legality check and ALU op select; anything not R/I ALU stays illegal
  always_comb begin
    alu_op = ALU_ADD;
    alu_src_imm = 1'b0;
    illegal = 1'b1;
    if (opcode == OP_R) begin
      if (funct7 == 7'b0000000) begin
        illegal = 1'b0;
        alu_op = f3_op(funct3);
      end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
        illegal = 1'b0;
        alu_op = funct3[2] ? ALU_SRA : ALU_SUB;
      end
    end else if (opcode == OP_I) begin
      alu_src_imm = 1'b1;
      illegal = funct3 == 3'b001 ? funct7 != 7'b0000000 :
                funct3 == 3'b101 ? (funct7 != 7'b0000000 && funct7 != 7'b0100000) : 1'b0;
      alu_op = (funct3 == 3'b101 && funct7[5]) ? ALU_SRA : f3_op(funct3);
    end
  end
endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle DECODE/EXEC/WB sequencer; CPU_CTRL_PERF_EN adds cycle/retire counters
module cpu_ctrl
  import cpu_pkg::*;
(
  input logic       clk,
  input logic       rst,
  cpu_ctrl_if.slave bus
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
`endif
);
  state_e      state_d, state_q;
  logic [31:0] ir_d, ir_q;
  logic        zero_d, zero_q;
  logic        dec_illegal;
  logic        hs;
  cpu_decode u_decode (
    .instr      (ir_q),
    .alu_op     (bus.alu_op),
    .alu_src_imm(bus.alu_src_imm),
    .imm        (bus.imm),
    .rs1_addr   (bus.rs1_addr),
    .rs2_addr   (bus.rs2_addr),
    .rd_addr    (bus.rd_addr),
    .illegal    (dec_illegal)
  );
  assign bus.in_ready = (state_q == S_IDLE || state_q == S_WB) && rst;
  assign hs = bus.in_valid && bus.in_ready;
  assign bus.illegal = state_q == S_DECODE && dec_illegal;
  assign bus.retire = state_q == S_WB;
  assign bus.rf_we = state_q == S_WB && bus.rd_addr != '0;
  assign bus.zero_q = zero_q;
  // Next state, instruction capture on accept, zero flag capture at end of EXEC
  always_comb begin
    state_d = hs ? S_DECODE :
              state_q == S_DECODE ? (dec_illegal ? S_IDLE : S_EXEC) :
              state_q == S_EXEC ? S_WB : S_IDLE;
    ir_d = hs ? bus.in : ir_q;
    zero_d = state_q == S_EXEC ? bus.zero : zero_q;
  end
  // Controller state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ir_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      zero_q <= zero_d;
    end
  end
`ifdef CPU_CTRL_PERF_EN
  logic [31:0] cycle_cnt_d, cycle_cnt_q, retire_cnt_d, retire_cnt_q;
  // Free-running cycle count and legal-retire count, both wrapping
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    retire_cnt_d = retire_cnt_q + {31'd0, bus.retire};
  end
  // Performance counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end
  assign cycle_cnt = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
`endif
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: vector table + scoreboard bench for cpu_ctrl
module tb_cpu_ctrl;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cpu_ctrl_if bus();
`ifdef CPU_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif
  cpu_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CPU_CTRL_PERF_EN
    ,
    .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt)
`endif
  );
  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        src;
    logic [31:0] imm;
  } vec_t;
  vec_t vecs[16];
  vec_t sb[$];
  vec_t mon_e;
  int checks = 0;
  int errors = 0;
  int n_retire = 0;
  int n_we = 0;
  int n_ill = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.retire) n_retire++;
    if (bus.rf_we) n_we++;
    if (bus.illegal) n_ill++;
    if (bus.retire || bus.illegal) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: got retire=%b illegal=%b with nothing outstanding", bus.retire, bus.illegal);
      end else begin
        mon_e = sb.pop_front();
        chk("illegal", bus.illegal, mon_e.ill);
        chk("retire", bus.retire, !mon_e.ill);
        chk("rf_we", bus.rf_we, !mon_e.ill && mon_e.rd != 0);
        if (!mon_e.ill) begin
          chk("rs1_addr", bus.rs1_addr, mon_e.rs1);
          chk("rs2_addr", bus.rs2_addr, mon_e.rs2);
          chk("rd_addr", bus.rd_addr, mon_e.rd);
          chk("alu_op", bus.alu_op, mon_e.op);
          chk("alu_src_imm", bus.alu_src_imm, mon_e.src);
          chk("imm", bus.imm, mon_e.imm);
        end
      end
    end
  end
  task automatic issue(input vec_t v);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in = v.instr;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", n < 20, 1);
    @(posedge clk);
    sb.push_back(v);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask
  task automatic trace(input vec_t v, input logic z, output logic [7:0] r, output logic [7:0] w,
                       output logic [7:0] il, output logic [7:0] rdy, output logic zq);
    r = '0; w = '0; il = '0; rdy = '0; zq = 1'b0;
    issue(v);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      r[c] = bus.retire;
      w[c] = bus.rf_we;
      il[c] = bus.illegal;
      rdy[c] = bus.in_ready;
      if (c == 3) zq = bus.zero_q;
      if (c == 2) bus.zero = z;
    end
    bus.zero = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] r, w, il, rdy;
    logic zq;
    logic [15:0] rmask, amask;
    int k, ret0;
    vecs[0]  = '{32'h002081B3, 1'b0, 5'd1,  5'd2,  5'd3,  4'd0, 1'b0, 32'h00000002};
    vecs[1]  = '{32'h06320813, 1'b0, 5'd4,  5'd3,  5'd16, 4'd0, 1'b1, 32'h00000063};
    vecs[2]  = '{32'h010803B3, 1'b0, 5'd16, 5'd16, 5'd7,  4'd0, 1'b0, 32'h00000010};
    vecs[3]  = '{32'hFFF20813, 1'b0, 5'd4,  5'd31, 5'd16, 4'd0, 1'b1, 32'hFFFFFFFF};
    vecs[4]  = '{32'h407302B3, 1'b0, 5'd6,  5'd7,  5'd5,  4'd1, 1'b0, 32'h00000407};
    vecs[5]  = '{32'h403150B3, 1'b0, 5'd2,  5'd3,  5'd1,  4'd7, 1'b0, 32'h00000403};
    vecs[6]  = '{32'h0020D1B3, 1'b0, 5'd1,  5'd2,  5'd3,  4'd6, 1'b0, 32'h00000002};
    vecs[7]  = '{32'h40455493, 1'b0, 5'd10, 5'd4,  5'd9,  4'd7, 1'b1, 32'h00000404};
    vecs[8]  = '{32'hFFB1B113, 1'b0, 5'd3,  5'd27, 5'd2,  4'd4, 1'b1, 32'hFFFFFFFB};
    vecs[9]  = '{32'h01DF7FB3, 1'b0, 5'd30, 5'd29, 5'd31, 4'd9, 1'b0, 32'h0000001D};
    vecs[10] = '{32'h00000013, 1'b0, 5'd0,  5'd0,  5'd0,  4'd0, 1'b1, 32'h00000000};
    vecs[11] = '{32'h00000073, 1'b1, 5'd0,  5'd0,  5'd0,  4'd0, 1'b0, 32'h00000000};
    vecs[12] = '{32'h022081B3, 1'b1, 5'd0,  5'd0,  5'd0,  4'd0, 1'b0, 32'h00000000};
    vecs[13] = '{32'h40001093, 1'b1, 5'd0,  5'd0,  5'd0,  4'd0, 1'b0, 32'h00000000};
    vecs[14] = '{32'h00002083, 1'b1, 5'd0,  5'd0,  5'd0,  4'd0, 1'b0, 32'h00000000};
    vecs[15] = '{32'h01F29293, 1'b0, 5'd5,  5'd31, 5'd5,  4'd2, 1'b1, 32'h0000001F};
    bus.in_valid = 1'b1;
    bus.in = 32'h002081B3;
    bus.zero = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_retire", bus.retire, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_zero_q", bus.zero_q, 0);
    chk("rst_rs1", bus.rs1_addr, 0);
    chk("rst_rs2", bus.rs2_addr, 0);
    chk("rst_rd", bus.rd_addr, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_src", bus.alu_src_imm, 0);
    chk("rst_imm", bus.imm, 0);
    bus.in_valid = 1'b0;
    bus.zero = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1);
    trace(vecs[0], 1'b1, r, w, il, rdy, zq);
    chk("add_retire_cyc", r, 8'h08);
    chk("add_rf_we_cyc", w, 8'h08);
    chk("add_illegal_cyc", il, 8'h00);
    chk("add_ready_cyc", rdy, 8'h18);
    chk("add_zero_q1", zq, 1);
    trace(vecs[11], 1'b0, r, w, il, rdy, zq);
    chk("ill_retire_cyc", r, 8'h00);
    chk("ill_rf_we_cyc", w, 8'h00);
    chk("ill_illegal_cyc", il, 8'h02);
    chk("ill_ready_cyc", rdy, 8'h1C);
    trace(vecs[10], 1'b1, r, w, il, rdy, zq);
    chk("x0_retire_cyc", r, 8'h08);
    chk("x0_rf_we_cyc", w, 8'h00);
    trace(vecs[1], 1'b0, r, w, il, rdy, zq);
    chk("addi_zero_q0", zq, 0);
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i]);
      wait_done();
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in = vecs[0].instr;
    sb.push_back(vecs[0]);
    k = 0;
    rmask = '0;
    amask = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      rmask[c] = bus.retire;
      amask[c] = bus.in_ready;
      if (bus.in_ready && k < 2) begin
        k++;
        bus.in = vecs[k].instr;
        sb.push_back(vecs[k]);
      end else if (bus.in_ready) begin
        bus.in_valid = 1'b0;
      end
    end
    chk("b2b_retire_cyc", rmask, 16'h0248);
    chk("b2b_ready_cyc", amask, 16'h0648);
    wait_done();
    ret0 = n_retire;
    issue(vecs[0]);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_rf_we", bus.rf_we, 0);
    chk("abort_retire", bus.retire, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_rd", bus.rd_addr, 0);
    repeat (2) @(negedge clk);
    chk("abort_hold_rf_we", bus.rf_we, 0);
    sb.delete();
    rst = 1'b1;
    #1;
    chk("abort_rel_ready", bus.in_ready, 1);
`ifdef CPU_CTRL_PERF_EN
    chk("abort_cycle_cnt", cycle_cnt, 0);
    chk("abort_retire_cnt", retire_cnt, 0);
`endif
    repeat (3) @(negedge clk);
    chk("abort_no_retire", n_retire, ret0);
    issue(vecs[1]);
    wait_done();
`ifdef CPU_CTRL_PERF_EN
    chk("post_retire_cnt", retire_cnt, 1);
`endif
    repeat (2) @(negedge clk);
    chk("total_retire", n_retire, 19);
    chk("total_rf_we", n_we, 17);
    chk("total_illegal", n_ill, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control sequencer for the single-issue RV32I integer datapath (register file + ALU). It accepts one 32-bit instruction per handshake and decodes R-type and I-type ALU instructions. It then steps the datapath through DECODE, EXEC and WB, driving register addresses, ALU operation, immediate and write-enable. Unsupported encodings are rejected with an illegal pulse, and the register file is never written for them.

## Interface
- `XLEN`, 32, datapath width
- `REG_AW`, 5, register address width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  controller can accept an instruction
- `in`  in  32  instruction word; sampled only on `in_valid && in_ready`
- `zero`  in  1  ALU zero flag from the datapath
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  REG_AW  register file addresses
- `alu_op`  out  4  ALU operation (`cpu_pkg` encoding)
- `alu_src_imm`  out  1  1 selects `imm` as ALU operand B
- `imm`  out  XLEN  sign-extended I-type immediate
- `rf_we`  out  1  register file write enable
- `retire`  out  1  one-cycle pulse per completed legal instruction
- `illegal`  out  1  one-cycle pulse per rejected instruction
- `zero_q`  out  1  `zero` captured at the end of EXEC

## Operation
- **States:** IDLE, DECODE, EXEC, WB.
- **Handshake:**
  - `in_ready` = (state==IDLE || state==WB) && rst.
  - On handshake, `in` is loaded into the instruction register and the state moves to DECODE.
- **IDLE:** holds until handshake.
- **DECODE:**
  - Drives decode outputs from the instruction register.
  - Illegal instruction → `illegal`=1, go to IDLE.
  - Legal instruction → go to EXEC.
- **EXEC:** decode outputs held; `zero_q` ← `zero` at end of cycle; go to WB.
- **WB:**
  - `rf_we`=1 unless `rd_addr`==0; `retire`=1 even when rd==0.
  - On handshake → DECODE, otherwise → IDLE.
- **Legal opcode 0110011 (R-type):**
  - funct7=0000000 with funct3 000/001/010/011/100/101/110/111 → ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7=0100000 with funct3 000/101 → SUB/SRA.
  - Everything else is illegal.
- **Legal opcode 0010011 (I-type):**
  - funct3 000/010/011/100/110/111 → ADD/SLT/SLTU/XOR/OR/AND.
  - SLLI requires funct7=0000000.
  - SRLI/SRAI require funct7=0000000/0100000.
  - Other funct7 values are illegal.
- **All other opcodes are illegal.**
- **Immediate:** `imm` = sign-extend(in[31:20]). `alu_src_imm`=1 only for I-type.
- **Output validity:** `rs1_addr`, `rs2_addr`, `rd_addr`, `alu_op`, `alu_src_imm` and `imm` are valid in DECODE, EXEC and WB. They come from registered state only; there is no combinational path from `in`/`in_valid`.
- **Reset values:**
  - state IDLE, instruction register 0.
  - `in_ready`, `rf_we`, `retire`, `illegal`, `zero_q` all 0.
  - All address/op/imm outputs 0.

## Timing
- Handshake at edge e0 puts DECODE in cycle 1, EXEC in cycle 2, WB in cycle 3. The register write commits at e3.
- Legal instruction: `retire` and `rf_we` high in cycle 3 only.
- Illegal instruction: `illegal` high in cycle 1, IDLE in cycle 2, `in_ready` high in cycle 2.
- Sustained throughput is one instruction per 3 cycles, because a new accept is allowed during WB.
- `in_valid` without `in_ready` has no effect, and `in` is ignored.
- Asserting `rst` mid-instruction:
  - Aborts immediately, with no `rf_we` or `retire` for the in-flight instruction.
  - Outputs are at reset values while `rst`=0.
  - `in_ready` rises in the first cycle after release.

## Configuration
- Macro: `CPU_CTRL_PERF_EN`.
- **Defined:**
  - Adds outputs `cycle_cnt` [31:0] and `retire_cnt` [31:0], both reset to 0.
  - `cycle_cnt` increments every cycle while out of reset.
  - `retire_cnt` increments on `retire`; illegal instructions are not counted.
  - Both wrap 0xFFFFFFFF → 0.
- **Undefined:** ports and counters are absent; all other behaviour is identical.

## Structure
- Package `cpu_pkg`:
  - opcode constants OP_R=7'b0110011, OP_I=7'b0010011
  - `alu_op` encoding ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9
  - state encoding
- Sub-module `cpu_decode`: purely combinational. Takes the instruction and produces `alu_op`, `alu_src_imm`, `imm`, register fields and `illegal`. `cpu_ctrl` holds the FSM, instruction register and counters.

## Test plan
- **Reset:** hold `rst`=0 with `in_valid`=1 → all outputs 0, `in_ready`=0. Release → `in_ready`=1 the next cycle.
- **add x3,x1,x2 (0x002081B3):**
  - `rs1_addr`=1, `rs2_addr`=2, `rd_addr`=3, `alu_op`=0, `alu_src_imm`=0.
  - `rf_we` and `retire` are single pulses in cycle 3.
- **addi x16,x4,99 (0x06320813):** `imm`=0x00000063, `alu_src_imm`=1, `rs1_addr`=4, `rd_addr`=16. Same with imm 0xFFF gives `imm`=0xFFFFFFFF.
- **Back-to-back stream:** `in_valid` held with 0x002081B3, 0x06320813, 0x010803B3 → accepts at e0, e3, e6 and `retire` in cycles 3, 6, 9.
- **Illegal and x0 destination:**
  - 0x00000073 and 0x022081B3 (funct7=0000001) → `illegal` pulse in cycle 1, no `rf_we`, no `retire`.
  - 0x00000013 (addi x0) → `retire`=1, `rf_we`=0.
- **Abort:** `rst`=0 during EXEC → no `rf_we`. With `CPU_CTRL_PERF_EN`, the counters read 0 after release, then `retire_cnt`=1 after one further legal instruction.
